dmem_responder: RTL

- Data-memory responder: the slave end of the core's load/store path.
- Accepts one request at a time (byte, half or word; load or store) over a valid/ready handshake, performs lane alignment and sign/zero extension, and serves it from an internal block-RAM word array.
- Returns one response per request on a second valid/ready channel.
- Sits between the core's load/store unit and on-chip BRAM; replaces direct raw-word memory wiring.

---
 rtl/dmem_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave in front of an
// internal word array, with big-endian lane alignment and load extension.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_e;

  logic [31:0]           mem [DEPTH];

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           ld_data_q, ld_data_d;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic                  req_err;
  logic [31:0]           rd_word;
  logic [31:0]           ld_ext;
  logic [3:0]            wr_be;
  logic [31:0]           wr_word;
  logic                  mem_we;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign accept  = req_valid & req_ready_q;
  assign idx     = req_addr[ADDR_WIDTH+1:2];
  assign off     = req_addr[1:0];
  assign rd_word = mem[idx];
  assign mem_we  = accept & req_write & ~req_err;

  // Request legality: size, alignment and word-index range
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = off[0];
      2'd2:    req_err = |off;
      default: req_err = 1'b1;
    endcase
    if (req_addr[31:ADDR_WIDTH+2] != '0) req_err = 1'b1;
  end

  // Load lane select (byte k lives in bits [31-8k:24-8k]) and extension
  always_comb begin
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    ld_ext  = '0;
    ld_byte = '0;
    ld_half = off[1] ? rd_word[15:0] : rd_word[31:16];
    case (off)
      2'd0:    ld_byte = rd_word[31:24];
      2'd1:    ld_byte = rd_word[23:16];
      2'd2:    ld_byte = rd_word[15:8];
      default: ld_byte = rd_word[7:0];
    endcase
    case (req_size)
      2'd0:    ld_ext = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{16{~req_unsigned & ld_half[15]}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  // Store lane enables and replicated write data (bit b of wr_be covers bits [8b+7:8b])
  always_comb begin
    wr_be   = 4'b0000;
    wr_word = req_wdata;
    case (req_size)
      2'd0: begin
        wr_be   = 4'b1000 >> off;
        wr_word = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        wr_be   = off[1] ? 4'b0011 : 4'b1100;
        wr_word = {2{req_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_word = req_wdata;
      end
    endcase
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_data_d    = ld_data_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          ld_data_d    = '0;
          if (req_err) begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end else if (req_write) begin
            state_d = RESP;
          end else if (READ_LATENCY == 1) begin
            resp_rdata_d = ld_ext;
            state_d      = RESP;
          end else begin
            ld_data_d = ld_ext;
            cnt_d     = CNT_W'(READ_LATENCY - 1);
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d        = '0;
          resp_rdata_d = ld_data_q;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ld_data_q    <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ld_data_q    <= ld_data_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage write on the acceptance edge; only enabled lanes change
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule
